// File: rtl/ysyx_24100029_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the
// fixed AXI read-address attributes and the default reset PC.
package ysyx_24100029_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC     = 32'h3000_0000;

    // Every fetch is a single 4-byte beat with ID 0.
    localparam logic [3:0]  AXI_ARID_FETCH   = 4'd0;
    localparam logic [7:0]  AXI_ARLEN_SINGLE = 8'd0;
    localparam logic [2:0]  AXI_SIZE_WORD    = 3'b010;
    localparam logic [1:0]  AXI_BURST_FIXED  = 2'b00;

endpackage

// File: rtl/ysyx_24100029_pc_reg.sv
// PC and fetch-address registers. A redirect always wins over sequential
// advance; ar_addr only moves when no read request is in flight.
module ysyx_24100029_pc_reg
    import ysyx_24100029_ifu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  ifu_state_e            state,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  r_fire,
    input  logic                  out_fire,
    input  logic                  kill,
    output logic [ADDR_WIDTH-1:0] ar_addr
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [ADDR_WIDTH-1:0] pc_seq;

    // Next PC and next fetch address, redirect first.
    always_comb begin
        pc_d      = pc_q;
        ar_addr_d = ar_addr_q;
        pc_seq    = pc_q + ADDR_WIDTH'(4);

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (out_fire) begin
            pc_d = pc_seq;
        end

        case (state)
            IFU_IDLE: begin
                if (redirect_valid) ar_addr_d = redirect_pc;
            end
            // AR request must stay stable, so ar_addr is untouched in IFU_AR.
            IFU_R: begin
                // A killed beat restarts fetch from the most recent redirect,
                // which pc_q already holds unless a newer one arrives now.
                if (r_fire) begin
                    if (redirect_valid) begin
                        ar_addr_d = redirect_pc;
                    end else if (kill) begin
                        ar_addr_d = pc_q;
                    end
                end
            end
            IFU_OUT: begin
                if (redirect_valid) begin
                    ar_addr_d = redirect_pc;
                end else if (out_fire) begin
                    ar_addr_d = pc_seq;
                end
            end
            default: ;
        endcase
    end

    // PC / fetch-address registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ar_addr_q <= RESET_PC;
        end else begin
            pc_q      <= pc_d;
            ar_addr_q <= ar_addr_d;
        end
    end

    assign ar_addr = ar_addr_q;

endmodule

// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: one outstanding single-beat AXI read toward the
// icache, result handed to the IDU with valid/ready. Redirects kill any
// in-flight fetch. Optional counters enabled by macro IFU_PERF_CNT_EN.
module ysyx_24100029_ifu
    import ysyx_24100029_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,

    output logic                  ifu_arvalid,
    output logic [ADDR_WIDTH-1:0] ifu_araddr,
    output logic [3:0]            ifu_arid,
    output logic [7:0]            ifu_arlen,
    output logic [2:0]            ifu_arsize,
    output logic [1:0]            ifu_arburst,
    input  logic                  ifu_arready,

    input  logic                  ifu_rvalid,
    input  logic [31:0]           ifu_rdata,
    input  logic [1:0]            ifu_rresp,
    input  logic                  ifu_rlast,
    input  logic [3:0]            ifu_rid,
    output logic                  ifu_rready,

    output logic                  out_valid,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_err,
    input  logic                  out_ready
`ifdef IFU_PERF_CNT_EN
   ,output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_wait_cnt
`endif
);

    ifu_state_e            state_q, state_d;
    logic                  kill_q, kill_d;
    logic [31:0]           out_inst_q, out_inst_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic                  out_err_q, out_err_d;

    logic                  ar_fire, r_fire, out_fire;
    logic [ADDR_WIDTH-1:0] ar_addr;

    logic                  unused_rid_rlast;
    assign unused_rid_rlast = ^{ifu_rid, ifu_rlast};

    assign ar_fire  = (state_q == IFU_AR)  && ifu_arready;
    assign r_fire   = (state_q == IFU_R)   && ifu_rvalid;
    assign out_fire = (state_q == IFU_OUT) && out_ready;

    ysyx_24100029_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (ADDR_WIDTH'(RESET_PC))
    ) u_pc_reg (
        .clock          (clock),
        .reset          (reset),
        .state          (state_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .r_fire         (r_fire),
        .out_fire       (out_fire),
        .kill           (kill_q),
        .ar_addr        (ar_addr)
    );

    // Next state, kill tracking and capture of the returned instruction.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        out_err_d  = out_err_q;

        case (state_q)
            IFU_IDLE: state_d = IFU_AR;
            IFU_AR: begin
                if (redirect_valid) kill_d = 1'b1;
                if (ar_fire)        state_d = IFU_R;
            end
            IFU_R: begin
                if (redirect_valid) kill_d = 1'b1;
                if (r_fire) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = IFU_AR;
                    end else begin
                        out_inst_d = ifu_rdata;
                        out_pc_d   = ar_addr;
                        out_err_d  = (ifu_rresp != 2'b00);
                        state_d    = IFU_OUT;
                    end
                end
            end
            IFU_OUT: begin
                if (redirect_valid || out_fire) state_d = IFU_AR;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    // FSM and output-holding registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IFU_IDLE;
            kill_q     <= 1'b0;
            out_inst_q <= '0;
            out_pc_q   <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            out_err_q  <= out_err_d;
        end
    end

    assign ifu_arvalid = (state_q == IFU_AR);
    assign ifu_araddr  = ar_addr;
    assign ifu_arid    = AXI_ARID_FETCH;
    assign ifu_arlen   = AXI_ARLEN_SINGLE;
    assign ifu_arsize  = AXI_SIZE_WORD;
    assign ifu_arburst = AXI_BURST_FIXED;
    assign ifu_rready  = (state_q == IFU_R);
    assign out_valid   = (state_q == IFU_OUT);
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
    assign out_err     = out_err_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Count delivered instructions and cycles spent waiting on the icache.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_wait_d  = perf_wait_q;
        if (out_fire) perf_fetch_d = perf_fetch_q + 32'd1;
        if ((state_q == IFU_AR) || (state_q == IFU_R)) perf_wait_d = perf_wait_q + 32'd1;
    end

    // Performance counter registers, wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_wait_q  <= perf_wait_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Bench for ysyx_24100029_ifu: directed scenarios followed by randomized
// traffic, checked against a transaction-level fetch model.
module tb_ysyx_24100029_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic [3:0]  ifu_rid;
    logic        ifu_rready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
    logic        out_ready;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    ysyx_24100029_ifu #(
        .RESET_PC   (32'h3000_0000),
        .ADDR_WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifu_arvalid    (ifu_arvalid),
        .ifu_araddr     (ifu_araddr),
        .ifu_arid       (ifu_arid),
        .ifu_arlen      (ifu_arlen),
        .ifu_arsize     (ifu_arsize),
        .ifu_arburst    (ifu_arburst),
        .ifu_arready    (ifu_arready),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rdata      (ifu_rdata),
        .ifu_rresp      (ifu_rresp),
        .ifu_rlast      (ifu_rlast),
        .ifu_rid        (ifu_rid),
        .ifu_rready     (ifu_rready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_err        (out_err),
        .out_ready      (out_ready)
`ifdef IFU_PERF_CNT_EN
       ,.perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    // Stimulus knobs and one-shot forces.
    int unsigned k_arready_pct  = 100;
    int unsigned k_outready_pct = 100;
    int unsigned k_redirect_pct = 0;
    int unsigned k_rdelay_min   = 0;
    int unsigned k_rdelay_max   = 0;
    bit          rst_in         = 1'b1;
    bit          f_redirect     = 1'b0;
    logic [31:0] f_redirect_pc  = '0;
    bit          f_rresp_en     = 1'b0;
    logic [1:0]  f_rresp        = 2'b00;

    // Reference model: architectural next-fetch PC, current request,
    // pending delivery, and the icache responder.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] req_addr = '0;
    bit          req_live = 1'b0;
    bit          ar_open = 1'b0;
    bit          out_pend = 1'b0;
    logic [31:0] exp_opc = '0, exp_oinst = '0;
    logic        exp_oerr = 1'b0;
    bit          resp_pending = 1'b0;
    int unsigned resp_wait = 0;
    logic [31:0] resp_addr = '0;
    bit          prev_rst = 1'b0;
    logic [31:0] m_fetch_cnt = '0, m_wait_cnt = '0;

    // Observations from the most recent tick.
    bit          t_ar_hs, t_arvalid, t_r_hs, t_out_valid, t_out_hs;
    logic [31:0] t_araddr, t_beat_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == RST_PC) return 32'h0000_0013;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit roll(input int unsigned pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample, check, advance model.
    task automatic tick();
        bit          idle, rd, ar_in, rv_in, or_in, ar_hs, r_hs, out_hs, exp_arv;
        logic [31:0] rd_pc, rdat;
        logic [1:0]  rr;
        @(negedge clock);
        idle  = prev_rst && !rst_in;
        ar_in = roll(k_arready_pct);
        or_in = roll(k_outready_pct);
        rd_pc = $urandom;
        rd_pc[1:0] = 2'b00;
        rd    = 1'b0;
        if (!rst_in && !idle) begin
            if (f_redirect) begin
                rd = 1'b1;
                rd_pc = f_redirect_pc;
                f_redirect = 1'b0;
            end else if (roll(k_redirect_pct)) begin
                rd = 1'b1;
            end
        end
        rv_in = !rst_in && resp_pending && (resp_wait == 0);
        rr = 2'b00;
        if (rv_in) begin
            if (f_rresp_en) begin
                rr = f_rresp;
                f_rresp_en = 1'b0;
            end else if (roll(12)) begin
                rr = roll(50) ? 2'b10 : 2'b11;
            end
        end
        rdat = rv_in ? mem_word(resp_addr) : $urandom;

        reset          = rst_in;
        ifu_arready    = ar_in;
        ifu_rvalid     = rv_in;
        ifu_rdata      = rdat;
        ifu_rresp      = rr;
        ifu_rlast      = rv_in;
        ifu_rid        = 4'd0;
        redirect_valid = rd;
        redirect_pc    = rd_pc;
        out_ready      = or_in;
        #1;

        t_ar_hs = 0; t_arvalid = 0; t_r_hs = 0; t_out_valid = 0; t_out_hs = 0;
        if (rst_in) begin
            m_pc = RST_PC; req_live = 0; ar_open = 0; out_pend = 0;
            resp_pending = 0; resp_wait = 0; m_fetch_cnt = '0; m_wait_cnt = '0;
            prev_rst = 1'b1;
            return;
        end

        exp_arv = !idle && !resp_pending && !out_pend;
        check("arvalid", ifu_arvalid, exp_arv);
        check("rready", ifu_rready, resp_pending);
        check("out_valid", out_valid, out_pend);
        if (idle) begin
            check("rst_out_inst", out_inst, 32'h0);
            check("rst_out_pc", out_pc, 32'h0);
            check("rst_out_err", out_err, 1'b0);
            check("arid", ifu_arid, 4'd0);
            check("arlen", ifu_arlen, 8'd0);
            check("arsize", ifu_arsize, 3'b010);
            check("arburst", ifu_arburst, 2'b00);
        end
        if (out_pend) begin
            check("out_pc", out_pc, exp_opc);
            check("out_inst", out_inst, exp_oinst);
            check("out_err", out_err, exp_oerr);
        end
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
        check("perf_wait", perf_wait_cnt, m_wait_cnt);
`endif

        ar_hs  = ifu_arvalid && ar_in;
        r_hs   = rv_in && ifu_rready;
        out_hs = out_valid && or_in;
        if (ifu_arvalid) begin
            if (!ar_open) begin
                check("araddr_new", ifu_araddr, m_pc);
                req_addr = m_pc;
                req_live = 1'b1;
            end else begin
                check("araddr_hold", ifu_araddr, req_addr);
            end
        end

        t_ar_hs = ar_hs; t_arvalid = ifu_arvalid; t_araddr = ifu_araddr;
        t_r_hs = r_hs; t_beat_addr = req_addr; t_out_valid = out_valid; t_out_hs = out_hs;

        if (out_hs) m_fetch_cnt++;
        if (exp_arv || resp_pending) m_wait_cnt++;
        if (out_hs && !rd) begin
            out_pend = 1'b0;
            m_pc = exp_opc + 32'd4;
        end
        if (resp_wait > 0) resp_wait--;
        if (r_hs) begin
            resp_pending = 1'b0;
            if (req_live && !rd) begin
                out_pend  = 1'b1;
                exp_opc   = req_addr;
                exp_oinst = mem_word(req_addr);
                exp_oerr  = (rr != 2'b00);
            end
        end
        if (ifu_arvalid) ar_open = !ar_hs;
        if (ar_hs) begin
            resp_pending = 1'b1;
            resp_addr    = ifu_araddr;
            resp_wait    = $urandom_range(k_rdelay_max, k_rdelay_min);
        end
        if (rd) begin
            m_pc = rd_pc;
            req_live = 1'b0;
            out_pend = 1'b0;
        end
        prev_rst = 1'b0;
    endtask

    // kind 0: AR handshake, 1: arvalid seen, 2: out_valid seen.
    task automatic wait_for(input int kind, input int unsigned budget, input string tag);
        bit got;
        got = 1'b0;
        for (int unsigned i = 0; i < budget && !got; i++) begin
            tick();
            case (kind)
                0:       got = t_ar_hs;
                1:       got = t_arvalid;
                default: got = t_out_valid;
            endcase
        end
        check(tag, got, 1'b1);
    endtask

    initial begin
        bit seen_ov, got;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ifu_arready = 1'b0;
        ifu_rvalid = 1'b0; ifu_rdata = '0; ifu_rresp = '0; ifu_rlast = 1'b0;
        ifu_rid = '0; out_ready = 1'b0;

        // Reset release and first fetch.
        rst_in = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        k_outready_pct = 0;
        f_rresp_en = 1'b1; f_rresp = 2'b00;
        tick();
        tick();
        check("first_ar_hs", t_ar_hs, 1'b1);
        check("first_araddr", t_araddr, 32'h3000_0000);
        tick();
        tick();
        check("first_out_valid", out_valid, 1'b1);
        check("first_out_inst", out_inst, 32'h0000_0013);
        check("first_out_pc", out_pc, 32'h3000_0000);

        // Back-pressure for five cycles in total.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_inst", out_inst, 32'h0000_0013);
            check("bp_no_ar", ifu_arvalid, 1'b0);
        end
        k_outready_pct = 100;
        k_rdelay_min = 3; k_rdelay_max = 3;
        tick();
        tick();
        check("bp_next_araddr", t_araddr, 32'h3000_0004);
        k_rdelay_min = 0; k_rdelay_max = 0;

        // Redirect while waiting in R.
        tick();
        f_redirect = 1'b1; f_redirect_pc = 32'h8000_0100;
        seen_ov = 1'b0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (t_out_valid) seen_ov = 1'b1;
            got = t_ar_hs;
        end
        check("r_redir_ar_seen", got, 1'b1);
        check("r_redir_no_out", seen_ov, 1'b0);
        check("r_redir_araddr", t_araddr, 32'h8000_0100);

        // Redirect while arready is held low.
        k_arready_pct = 0;
        wait_for(1, 20, "ar_stall_arvalid_seen");
        check("ar_stall_araddr", t_araddr, 32'h8000_0104);
        f_redirect = 1'b1; f_redirect_pc = 32'h8000_0200;
        repeat (4) tick();
        check("ar_stall_arvalid_hold", ifu_arvalid, 1'b1);
        check("ar_stall_araddr_hold", ifu_araddr, 32'h8000_0104);
        k_arready_pct = 100;
        wait_for(0, 10, "ar_stall_hs_seen");
        check("ar_stall_hs_addr", t_araddr, 32'h8000_0104);
        wait_for(0, 10, "ar_stall_refetch_seen");
        check("ar_stall_refetch_addr", t_araddr, 32'h8000_0200);

        // Redirect on the same cycle as the OUT handshake at 0x3000_0010.
        rst_in = 1'b1;
        repeat (2) tick();
        rst_in = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = t_r_hs && (t_beat_addr == 32'h3000_0010);
        end
        check("out_redir_beat_seen", got, 1'b1);
        f_redirect = 1'b1; f_redirect_pc = 32'h8000_1000;
        tick();
        check("out_redir_hs", t_out_hs, 1'b1);
        wait_for(0, 10, "out_redir_ar_seen");
        check("out_redir_araddr", t_araddr, 32'h8000_1000);

        // Error response.
        f_rresp_en = 1'b1; f_rresp = 2'b10;
        wait_for(2, 10, "err_out_seen");
        check("err_out_err", out_err, 1'b1);
        check("err_out_pc", out_pc, 32'h8000_1000);

        // Randomized traffic with occasional mid-transaction reset.
        for (int unsigned n = 0; n < 4000; n++) begin
            if (n % 400 == 0) begin
                k_arready_pct  = $urandom_range(100, 30);
                k_outready_pct = $urandom_range(100, 30);
                k_redirect_pct = $urandom_range(12, 0);
                k_rdelay_min   = 0;
                k_rdelay_max   = $urandom_range(3, 0);
            end
            if ($urandom_range(299, 0) == 0) begin
                rst_in = 1'b1;
                repeat ($urandom_range(2, 1)) tick();
                rst_in = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
